hostlink_mgr: RTL and testbench
===============================

# hostlink_mgr

Parametrised UART-side host bridge: parses a byte command stream from the UART receiver and performs memory block reads/writes, register-file reads/writes and a CPU cede request, returning response bytes through the UART transmitter. Sits between the UART rx/tx pair and the memory/register-file debug ports of the rv32i core. Generalises the earlier single-byte-wide manager to configurable address, word and length widths, adds register-file writes and a status ping, and adds an optional checksum.

## Interface
- AW, 19, memory word-address width
- DW, 8, memory word width in bits; multiple of 8; NB = DW/8 bytes per word
- LW, 16, length field width in words; multiple of 8
- RD_LAT, 2, cycles from mem_ad change to valid mem_rd; 1..4

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
- rx_data  in  8  received byte
- tx_ready  in  1  transmitter accepts tx_data this cycle when tx_valid=1
- tx_valid  out  1  tx_data valid
- tx_data  out  8  byte to transmit
- mem_ad  out  AW  memory word address
- mem_rd  in  DW  memory read data
- mem_we  out  1  memory write strobe, one cycle per word
- mem_wd  out  DW  memory write data
- rf_ra  out  5  register read index; rf_rd valid next cycle
- rf_rd  in  32  register read data
- rf_we  out  1  register write strobe
- rf_wa  out  5  register write index
- rf_wd  out  32  register write data
- cede  out  1  one-cycle pulse: hand memory/execution back to core
- busy  out  1  high whenever state != IDLE

## Operation
- Header byte: [2:0] op, [7:3] ignored. Multi-byte fields little-endian. AB = ceil(AW/8) address bytes (excess bits ignored), LB = LW/8 length bytes.
- op 0 MRD: AB addr, LB len; returns len words, each NB bytes LSB first.
- op 1 MWR: AB addr, LB len, then len*NB data bytes LSB first.
- op 2 RRD: 1 index byte ([4:0]); returns 4 bytes LSB first.
- op 3 CEDE: no fields; cede pulses.
- op 4 RWR: 1 index byte, 4 data bytes; rf_we pulses; no response.
- op 5 PING: returns one byte 0xA5.
- op 6/7: ignored; stay IDLE.
- States: IDLE, FIELDS (byte counter over operand bytes), MRD_ISSUE, MRD_WAIT, MRD_SEND, MWR_COLLECT, MWR_STROBE, RRD_WAIT, RRD_SEND, RWR_STROBE, SEND1 (single-byte response), CKSUM (macro only).
- Address increments by 1 per word, wraps modulo 2^AW; len==0: no data phase, return to IDLE (CKSUM first if enabled).
- rx bytes arriving in MRD_*, RRD_*, SEND1, CKSUM are dropped; in MWR_STROBE they are captured.
- Reset values: all outputs 0; state IDLE; counters, shift buffers 0. rst low mid-command aborts immediately; partial words never written.

## Timing
- Byte transfers on tx_valid && tx_ready; tx_data stable while tx_valid && !tx_ready.
- MRD: mem_ad = addr one cycle after last field byte; mem_rd sampled RD_LAT cycles later into NB-byte shift buffer, tx_valid rises same edge; next word address issued at load, so inter-word gap ≤ RD_LAT cycles with tx_valid low.
- MWR: mem_we high exactly one cycle, the cycle after the NB-th byte, mem_ad/mem_wd stable that cycle; mem_ad increments next cycle.
- RRD: rf_ra set one cycle after index byte; rf_rd captured next cycle; tx_valid then.
- CEDE: cede high the cycle after the header byte; state stays IDLE.
- RWR: rf_we one cycle, the cycle after the 4th data byte.

## Configuration
- HOSTLINK_CKSUM_EN defined: MRD and RRD append one byte = XOR of all response payload bytes (0x00 if len==0); MWR and RWR expect one trailing byte = XOR of data bytes, then respond one byte 0x00 match / 0xFF mismatch (writes already performed regardless).
- Undefined: no checksum bytes sent or expected; CKSUM state absent.

## Test plan
- DW=32, AW=19: MWR addr 0x00010, len 2, bytes 11 22 33 44 55 66 77 88 -> mem_we twice: 0x00010=0x44332211, 0x00011=0x88776655.
- Then MRD addr 0x00010 len 2, tx_ready always 1 -> tx bytes 11 22 33 44 55 66 77 88; with tx_ready stalled 5 cycles per byte -> same bytes, tx_data held.
- MRD addr 0x7FFFF len 2 -> reads 0x7FFFF then 0x00000 (wrap); len 0 -> no bytes, busy low within 2 cycles.
- RWR index 7 data EF BE AD DE -> rf_we once, rf_wa=7, rf_wd=0xDEADBEEF; RRD index 7 with rf_rd=0xDEADBEEF -> EF BE AD DE.
- Header 0x03 -> cede single-cycle pulse; header 0x05 -> one byte 0xA5; header 0x06 -> no response, busy stays 0.
- rst low after 3rd of 8 MWR data bytes -> no mem_we, outputs 0; next command executes normally. With HOSTLINK_CKSUM_EN: RRD of 0xDEADBEEF -> EF BE AD DE 22.

Source files
------------

// File: rtl/hostlink_mgr.sv
// hostlink_mgr: UART-side host bridge for the rv32i core.
// Parses a byte command stream from the UART receiver and performs memory
// block reads/writes, register-file reads/writes, a status ping and a CPU
// cede request. Response bytes go out through the UART transmitter.
//
// Commands: the low 3 bits of the header byte select the op; all multi-byte
// fields are little-endian.
//   0 MRD  addr, len -> len words, LSB first
//   1 MWR  addr, len, len*NB data bytes
//   2 RRD  index     -> 4 bytes, LSB first
//   3 CEDE           -> cede pulse
//   4 RWR  index, 4 data bytes
//   5 PING           -> 0xA5
//
// Optional build macro HOSTLINK_CKSUM_EN: reads append an XOR checksum byte;
// writes expect a trailing XOR byte and answer 0x00 (match) / 0xFF (mismatch).
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   rx_valid, rx_data   received byte strobe and data
//   tx_ready, tx_valid, tx_data   transmit handshake and byte
//   mem_ad, mem_rd, mem_we, mem_wd   memory debug port (word addressed)
//   rf_ra, rf_rd        register read index / data (data valid next cycle)
//   rf_we, rf_wa, rf_wd register write strobe / index / data
//   cede                one-cycle pulse handing execution back to the core
//   busy                high whenever a command is in progress
module hostlink_mgr #(
  parameter int AW     = 19,
  parameter int DW     = 8,
  parameter int LW     = 16,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          tx_ready,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  output logic [AW-1:0] mem_ad,
  input  logic [DW-1:0] mem_rd,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  output logic [4:0]    rf_ra,
  input  logic [31:0]   rf_rd,
  output logic          rf_we,
  output logic [4:0]    rf_wa,
  output logic [31:0]   rf_wd,
  output logic          cede,
  output logic          busy
);

  localparam int NB  = DW / 8;
  localparam int AB  = (AW + 7) / 8;
  localparam int LB  = LW / 8;
  localparam int FB  = (AB + LB > 5) ? AB + LB : 5;
  localparam int SW  = (DW > 32) ? DW : 32;
  localparam int SB  = SW / 8;
  localparam int FCW = $clog2(FB + 1);
  localparam int BCW = $clog2(SB + 1);
  localparam int LCW = 3;

  localparam logic [2:0] OP_MRD  = 3'd0;
  localparam logic [2:0] OP_MWR  = 3'd1;
  localparam logic [2:0] OP_RRD  = 3'd2;
  localparam logic [2:0] OP_CEDE = 3'd3;
  localparam logic [2:0] OP_RWR  = 3'd4;
  localparam logic [2:0] OP_PING = 3'd5;

  typedef enum logic [3:0] {
    IDLE, FIELDS, MRD_ISSUE, MRD_WAIT, MRD_SEND, MWR_COLLECT, MWR_STROBE,
    RRD_WAIT, RRD_SEND, RWR_STROBE, SEND1
`ifdef HOSTLINK_CKSUM_EN
    , CKSUM
`endif
  } state_t;

  state_t          state;
  logic [2:0]      op;
  logic [FCW-1:0]  nf;
  logic [FCW-1:0]  fcnt;
  logic [FB*8-1:0] fld;
  logic [LW-1:0]   rem;
  logic [SW-1:0]   shbuf;
  logic [BCW-1:0]  bcnt;
  logic [BCW-1:0]  blast;
  logic [LCW-1:0]  lcnt;
  logic [DW-1:0]   wbuf;

  logic [FB*8-1:0] fld_nx;
  logic [LW-1:0]   fld_len;
  logic [DW-1:0]   wbuf_nx;
  logic [SW-1:0]   shbuf_sh;
  logic            lat_ok;

`ifdef HOSTLINK_CKSUM_EN
  logic [7:0] cksum;
  logic       ck_rx;
  logic [7:0] ck_resp;

  function automatic logic [7:0] xor_bytes(input logic [SW-1:0] w);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < SB; i++) x = x ^ w[i*8 +: 8];
    return x;
  endfunction

  assign ck_resp = (rx_data == cksum) ? 8'h00 : 8'hFF;
`endif

  // Field and write-word buffers with the incoming byte already merged, so
  // the last byte of a field or word can be acted on in the same cycle.
  always_comb begin
    fld_nx  = fld;
    wbuf_nx = wbuf;
    for (int i = 0; i < FB; i++)
      if (fcnt == FCW'(i)) fld_nx[i*8 +: 8] = rx_data;
    for (int i = 0; i < NB; i++)
      if (bcnt == BCW'(i)) wbuf_nx[i*8 +: 8] = rx_data;
  end

  assign fld_len  = fld_nx[AB*8 +: LW];
  assign shbuf_sh = shbuf >> 8;
  // lcnt counts edges since mem_ad last changed; data is usable on the
  // RD_LAT-th edge after the change.
  assign lat_ok   = (lcnt >= LCW'(RD_LAT - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      op       <= '0;
      nf       <= '0;
      fcnt     <= '0;
      fld      <= '0;
      rem      <= '0;
      shbuf    <= '0;
      bcnt     <= '0;
      blast    <= '0;
      lcnt     <= '0;
      wbuf     <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      mem_ad   <= '0;
      mem_we   <= 1'b0;
      mem_wd   <= '0;
      rf_ra    <= '0;
      rf_we    <= 1'b0;
      rf_wa    <= '0;
      rf_wd    <= '0;
      cede     <= 1'b0;
`ifdef HOSTLINK_CKSUM_EN
      cksum    <= '0;
      ck_rx    <= 1'b0;
`endif
    end else begin
      cede <= 1'b0;
      if (lcnt != LCW'(RD_LAT)) lcnt <= lcnt + 1'b1;
      case (state)
        IDLE: if (rx_valid) begin
          op   <= rx_data[2:0];
          fcnt <= '0;
          fld  <= '0;
`ifdef HOSTLINK_CKSUM_EN
          cksum <= '0;
          ck_rx <= 1'b0;
`endif
          case (rx_data[2:0])
            OP_MRD, OP_MWR: begin nf <= FCW'(AB + LB); state <= FIELDS; end
            OP_RRD:  begin nf <= FCW'(1); state <= FIELDS; end
            OP_RWR:  begin nf <= FCW'(5); state <= FIELDS; end
            OP_CEDE: cede <= 1'b1;
            OP_PING: begin tx_data <= 8'hA5; tx_valid <= 1'b1; state <= SEND1; end
            default: ;
          endcase
        end

        FIELDS: if (rx_valid) begin
          fld  <= fld_nx;
          fcnt <= fcnt + 1'b1;
`ifdef HOSTLINK_CKSUM_EN
          if (op == OP_RWR && fcnt != '0) cksum <= cksum ^ rx_data;
`endif
          if (fcnt == nf - 1'b1) begin
            case (op)
              OP_MRD: begin
                mem_ad <= fld_nx[AW-1:0];
                lcnt   <= '0;
                rem    <= fld_len;
                if (fld_len == '0) begin
`ifdef HOSTLINK_CKSUM_EN
                  tx_data  <= 8'h00;
                  tx_valid <= 1'b1;
                  state    <= CKSUM;
`else
                  state    <= IDLE;
`endif
                end else begin
                  state <= MRD_ISSUE;
                end
              end
              OP_MWR: begin
                mem_ad <= fld_nx[AW-1:0];
                rem    <= fld_len;
                bcnt   <= '0;
                wbuf   <= '0;
                if (fld_len == '0) begin
`ifdef HOSTLINK_CKSUM_EN
                  ck_rx <= 1'b1;
                  state <= CKSUM;
`else
                  state <= IDLE;
`endif
                end else begin
                  state <= MWR_COLLECT;
                end
              end
              OP_RRD: begin
                rf_ra <= rx_data[4:0];
                lcnt  <= '0;
                state <= RRD_WAIT;
              end
              default: begin
                rf_wa <= fld_nx[4:0];
                rf_wd <= fld_nx[39:8];
                rf_we <= 1'b1;
                state <= RWR_STROBE;
              end
            endcase
          end
        end

        // MRD_ISSUE holds the first word in flight, MRD_WAIT later ones; the
        // following word address is issued as soon as a word is loaded so
        // its read latency overlaps transmission.
        MRD_ISSUE, MRD_WAIT: if (lat_ok) begin
          shbuf    <= SW'(mem_rd);
          tx_data  <= mem_rd[7:0];
          tx_valid <= 1'b1;
          bcnt     <= '0;
          blast    <= BCW'(NB - 1);
          rem      <= rem - 1'b1;
`ifdef HOSTLINK_CKSUM_EN
          cksum    <= cksum ^ xor_bytes(SW'(mem_rd));
`endif
          if (rem != LW'(1)) begin
            mem_ad <= mem_ad + 1'b1;
            lcnt   <= '0;
          end
          state <= MRD_SEND;
        end

        MRD_SEND, RRD_SEND: if (tx_valid && tx_ready) begin
          if (bcnt == blast) begin
            tx_valid <= 1'b0;
            if (state == MRD_SEND && rem != '0) begin
              state <= MRD_WAIT;
            end else begin
`ifdef HOSTLINK_CKSUM_EN
              tx_data  <= cksum;
              tx_valid <= 1'b1;
              state    <= CKSUM;
`else
              state    <= IDLE;
`endif
            end
          end else begin
            bcnt    <= bcnt + 1'b1;
            shbuf   <= shbuf_sh;
            tx_data <= shbuf_sh[7:0];
          end
        end

        // A byte landing in the strobe cycle belongs to the next word.
        MWR_COLLECT, MWR_STROBE: begin
          if (state == MWR_STROBE) begin
            mem_we <= 1'b0;
            mem_ad <= mem_ad + 1'b1;
          end
          if (state == MWR_STROBE && rem == '0) begin
`ifdef HOSTLINK_CKSUM_EN
            if (rx_valid) begin
              tx_data  <= ck_resp;
              tx_valid <= 1'b1;
            end else begin
              ck_rx <= 1'b1;
            end
            state <= CKSUM;
`else
            state <= IDLE;
`endif
          end else if (rx_valid) begin
`ifdef HOSTLINK_CKSUM_EN
            cksum <= cksum ^ rx_data;
`endif
            if (bcnt == BCW'(NB - 1)) begin
              mem_wd <= wbuf_nx;
              mem_we <= 1'b1;
              rem    <= rem - 1'b1;
              bcnt   <= '0;
              wbuf   <= '0;
              state  <= MWR_STROBE;
            end else begin
              wbuf  <= wbuf_nx;
              bcnt  <= bcnt + 1'b1;
              state <= MWR_COLLECT;
            end
          end else if (state == MWR_STROBE) begin
            state <= MWR_COLLECT;
          end
        end

        // rf_ra presented one cycle, rf_rd valid the next; capture on the
        // second edge after the index was latched.
        RRD_WAIT: if (lcnt == LCW'(1)) begin
          shbuf    <= SW'(rf_rd);
          tx_data  <= rf_rd[7:0];
          tx_valid <= 1'b1;
          bcnt     <= '0;
          blast    <= BCW'(3);
`ifdef HOSTLINK_CKSUM_EN
          cksum    <= cksum ^ xor_bytes(SW'(rf_rd));
`endif
          state    <= RRD_SEND;
        end

        RWR_STROBE: begin
          rf_we <= 1'b0;
`ifdef HOSTLINK_CKSUM_EN
          if (rx_valid) begin
            tx_data  <= ck_resp;
            tx_valid <= 1'b1;
          end else begin
            ck_rx <= 1'b1;
          end
          state <= CKSUM;
`else
          state <= IDLE;
`endif
        end

        SEND1: if (tx_ready) begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end

`ifdef HOSTLINK_CKSUM_EN
        // Either waiting for the host's checksum byte or sending ours.
        CKSUM: begin
          if (ck_rx) begin
            if (rx_valid) begin
              tx_data  <= ck_resp;
              tx_valid <= 1'b1;
              ck_rx    <= 1'b0;
            end
          end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hostlink_mgr.sv
// Directed bench for hostlink_mgr with 32-bit memory words.
module tb_hostlink_mgr;
  localparam int AW = 19;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_ready = 1'b1;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic [AW-1:0] mem_ad;
  logic [DW-1:0] mem_rd = '0;
  logic          mem_we;
  logic [DW-1:0] mem_wd;
  logic [4:0]    rf_ra;
  logic [31:0]   rf_rd = 32'hDEADBEEF;
  logic          rf_we;
  logic [4:0]    rf_wa;
  logic [31:0]   rf_wd;
  logic          cede;
  logic          busy;

  always #5 clk = ~clk;

  hostlink_mgr #(.AW(AW), .DW(DW), .LW(LW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .mem_ad(mem_ad), .mem_rd(mem_rd), .mem_we(mem_we), .mem_wd(mem_wd),
    .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .cede(cede), .busy(busy)
  );

  // Memory model: data for an address is presented one edge after mem_ad
  // changes, so it is stable by the RD_LAT=2 sampling edge.
  logic [DW-1:0] mem [logic [AW-1:0]];
  always @(posedge clk) begin
    mem_rd <= mem.exists(mem_ad) ? mem[mem_ad] : '0;
    if (mem_we) mem[mem_ad] = mem_wd;
  end

  int checks = 0;
  int failures = 0;
  logic [7:0]    tx_log[$];
  logic [7:0]    exp_q[$];
  logic [7:0]    cmd[$];
  logic [AW-1:0] we_ad[$];
  logic [DW-1:0] we_wd[$];
  int            rf_we_n = 0;
  logic [4:0]    rf_wa_s = '0;
  logic [31:0]   rf_wd_s = '0;
  int            cede_n = 0;
  int            busy_n = 0;
  int            hold_viol = 0;
  logic          hold_pend = 1'b0;
  logic [7:0]    hold_data = '0;
  logic          stall_mode = 1'b0;
  int            scnt = 0;

  // Monitor and transmitter-side ready generator, away from the active edge.
  always @(negedge clk) begin
    if (stall_mode) begin
      if (tx_valid) begin
        if (scnt == 5) begin tx_ready = 1'b1; scnt = 0; end
        else begin tx_ready = 1'b0; scnt++; end
      end else begin
        tx_ready = 1'b0;
        scnt = 0;
      end
    end else begin
      tx_ready = 1'b1;
    end
    if (hold_pend && tx_data !== hold_data) hold_viol++;
    hold_pend = tx_valid && !tx_ready;
    hold_data = tx_data;
    if (tx_valid && tx_ready) tx_log.push_back(tx_data);
    if (mem_we) begin we_ad.push_back(mem_ad); we_wd.push_back(mem_wd); end
    if (rf_we) begin rf_we_n++; rf_wa_s = rf_wa; rf_wd_s = rf_wd; end
    if (cede) cede_n++;
    if (busy) busy_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xq(input logic [7:0] q[$]);
    logic [7:0] x;
    x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    return x;
  endfunction

  // Called at posedge+1; returns at posedge+1 after a 3-cycle gap.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd();
    foreach (cmd[i]) send_byte(cmd[i]);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < budget);
    chk({tag, "_idle"}, busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_tx(input string tag);
    logic [31:0] got;
    chk({tag, "_cnt"}, tx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < tx_log.size()) ? {24'h0, tx_log[i]} : 32'hFFFF_FFFF;
      chk($sformatf("%s_b%0d", tag, i), got, {24'h0, exp_q[i]});
    end
    exp_q.delete();
    tx_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_memwe", mem_we, 1'b0);
    chk("rst_memad", mem_ad, '0);
    chk("rst_cede", cede, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Block write of two words; header upper bits must be ignored.
    we_ad.delete(); we_wd.delete();
    cmd = '{8'hF9, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_cmd();
`ifdef HOSTLINK_CKSUM_EN
    send_byte(8'h88);
    exp_q.push_back(8'h00);
`endif
    wait_idle("mwr", 300);
    chk("mwr_n", we_ad.size(), 2);
    if (we_ad.size() == 2) begin
      chk("mwr_ad0", we_ad[0], 19'h00010);
      chk("mwr_wd0", we_wd[0], 32'h44332211);
      chk("mwr_ad1", we_ad[1], 19'h00011);
      chk("mwr_wd1", we_wd[1], 32'h88776655);
    end
    check_tx("mwr_rsp");

    // Read back, transmitter always ready.
    tx_log.delete();
    cmd = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00};
    send_cmd();
    wait_idle("mrd", 300);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef HOSTLINK_CKSUM_EN
    exp_q.push_back(xq(exp_q));
`endif
    check_tx("mrd");

    // Same read with 5 stall cycles per byte; tx_data must hold.
    hold_viol = 0;
    stall_mode = 1'b1;
    send_cmd();
    wait_idle("mrds", 600);
    stall_mode = 1'b0;
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef HOSTLINK_CKSUM_EN
    exp_q.push_back(xq(exp_q));
`endif
    check_tx("mrds");
    chk("mrds_hold", hold_viol, 0);

    // Address wrap; excess address bits in the top byte are ignored.
    mem[19'h7FFFF] = 32'hA1B2C3D4;
    mem[19'h00000] = 32'h0A0B0C0D;
    cmd = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00};
    send_cmd();
    wait_idle("wrap", 300);
    exp_q = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
`ifdef HOSTLINK_CKSUM_EN
    exp_q.push_back(xq(exp_q));
`endif
    check_tx("wrap");

    // Zero-length read.
    cmd = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
    send_cmd();
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
`ifdef HOSTLINK_CKSUM_EN
    wait_idle("len0", 100);
    exp_q.push_back(8'h00);
`else
    chk("len0_busy", busy, 1'b0);
    repeat (4) @(posedge clk); #1;
`endif
    check_tx("len0");

    // Register write then read back.
    rf_we_n = 0;
    cmd = '{8'h04, 8'h07, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_cmd();
`ifdef HOSTLINK_CKSUM_EN
    send_byte(8'h22);
    exp_q.push_back(8'h00);
`endif
    wait_idle("rwr", 100);
    chk("rwr_n", rf_we_n, 1);
    chk("rwr_wa", rf_wa_s, 5'd7);
    chk("rwr_wd", rf_wd_s, 32'hDEADBEEF);
    check_tx("rwr_rsp");

    cmd = '{8'h02, 8'h07};
    send_cmd();
    wait_idle("rrd", 100);
    chk("rrd_ra", rf_ra, 5'd7);
    exp_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef HOSTLINK_CKSUM_EN
    exp_q.push_back(8'h22);
`endif
    check_tx("rrd");

    // Cede, ping, ignored op.
    cede_n = 0;
    send_byte(8'h03);
    chk("cede_n", cede_n, 1);
    chk("cede_busy", busy, 1'b0);

    send_byte(8'h05);
    wait_idle("ping", 50);
    exp_q = '{8'hA5};
    check_tx("ping");

    busy_n = 0;
    send_byte(8'h06);
    repeat (4) @(posedge clk); #1;
    chk("op6_busy", busy_n, 0);
    check_tx("op6");

    // Reset in the middle of a block write.
    we_ad.delete(); we_wd.delete();
    cmd = '{8'h01, 8'h20, 8'h00, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    send_cmd();
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("mrst_we_n", we_ad.size(), 0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_memad", mem_ad, '0);
    chk("mrst_memwd", mem_wd, '0);
    chk("mrst_txv", tx_valid, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    cmd = '{8'h01, 8'h30, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_cmd();
`ifdef HOSTLINK_CKSUM_EN
    send_byte(8'h04);
    exp_q.push_back(8'h00);
`endif
    wait_idle("post", 200);
    chk("post_n", we_ad.size(), 1);
    if (we_ad.size() == 1) begin
      chk("post_ad", we_ad[0], 19'h00030);
      chk("post_wd", we_wd[0], 32'h04030201);
    end
    check_tx("post_rsp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
